cnt_seq_checker: RTL and testbench
==================================

# cnt_seq_checker

Sequence checker that consumes the parallel count stream produced by the free-running counter and confirms that it advances by exactly one, modulo 2^WIDTH, on every qualified sample. It acquires lock after a run of correct increments, then flags, counts and (if persistent) drops lock on sequence errors. It also counts wrap-arounds. It sits downstream of the counter, in the same clock domain, as an in-design monitor and as the self-checking end of the counter bench.

## Interface
- WIDTH, 5: width of the observed count.
- LOCK_N, 4: consecutive correct increments required to assert lock (≥1).
- UNLOCK_N, 2: consecutive mismatches while locked that drop lock (≥1).
- STAT_W, 8: width of the error and wrap statistics counters.

- clk  in  1: clock, rising edge.
- rst  in  1: reset, asynchronous, active-high.
- en  in  1: sample qualifier; cnt_in is only examined when en=1.
- cnt_in  in  WIDTH: observed count value.
- clr_stat  in  1: synchronous clear of err_cnt and wrap_cnt.
- locked  out  1: high while FSM is in LOCK.
- err_pulse  out  1: one-cycle pulse per mismatch detected in LOCK.
- err_cnt  out  STAT_W: saturating count of err_pulse events.
- wrap_pulse  out  1: one-cycle pulse per all-ones→0 transition observed.
- wrap_cnt  out  STAT_W: saturating count of wrap_pulse events.

## Operation
- Internal registers: prev (WIDTH), match_cnt (enough bits for LOCK_N), miss_cnt (enough bits for UNLOCK_N), and a 2-bit state.
- Expected value: exp = prev + 1, truncated to WIDTH bits. All-ones+1 = 0 is correct. "Hold" (cnt_in == prev) is a mismatch.
- Every en sample loads prev ← cnt_in, in all states.
- FSM states: IDLE, SYNC, LOCK.
  - IDLE: the first en sample loads prev only → SYNC, match_cnt=0.
  - SYNC, correct sample: match_cnt+1. When it reaches LOCK_N → LOCK, miss_cnt=0.
  - SYNC, mismatch: match_cnt=0. No err_pulse.
  - LOCK, correct sample: miss_cnt=0.
  - LOCK, mismatch: err_pulse=1; err_cnt+1, saturating at all-ones; miss_cnt+1. When it reaches UNLOCK_N → SYNC, match_cnt=0.
- Wrap: in SYNC or LOCK, an en sample with prev=all-ones and cnt_in=0 gives wrap_pulse=1 and wrap_cnt+1 (saturating). A wrap is detected even while unlocked.
- clr_stat: both stat counters ← 0. If clr_stat coincides with an increment, clear wins (result 0). Pulses still fire.
- en=0: no state, prev or counter change. Pulses are 0.

## Timing
- All outputs are registered. For a sample taken at edge N, locked, err_pulse, wrap_pulse and the counters reflect it after edge N.
- locked rises on the edge that accepts the LOCK_N-th correct increment. With continuous en, that is LOCK_N+1 samples after leaving IDLE.
- locked falls on the edge that records the UNLOCK_N-th consecutive mismatch. err_pulse is also high in that same cycle.
- Reset values (async, immediate): state=IDLE, locked=0, err_pulse=0, wrap_pulse=0, err_cnt=0, wrap_cnt=0, prev=0, match_cnt=0, miss_cnt=0.
- Reset asserted mid-operation returns to IDLE at once. After release, lock must be fully re-acquired.
- cnt_in carrying X/Z is not specified. The checker is only required to behave for known values; the bench keeps en=0 until the source leaves reset.

## Structure
- Shared package cnt_pkg holds:
  - the state encoding constants (IDLE=2'd0, SYNC=2'd1, LOCK=2'd2);
  - the default WIDTH=5, shared with the counter.
- One natural sub-module, sat_counter (parameter STAT_W; inputs inc and clr; clr has priority). It is instantiated twice, for err_cnt and wrap_cnt.
- The FSM, prev register and compare logic live in the top module.

## Test plan
- Reset then a clean ramp 0,1,2,… with en=1 → locked rises on the edge accepting value 4 (LOCK_N=4). err_cnt=0 throughout.
- Ramp through 0x1E,0x1F,0x00,0x01 → one wrap_pulse on the 0x00 sample, wrap_cnt=1, locked stays 1, no err_pulse.
- Locked, then inject 0x07,0x09,0x0A → single err_pulse on 0x09, err_cnt=1, locked stays 1 (0x0A correct vs prev 0x09).
- Locked, then 0x05,0x05,0x05 → err_pulse on the 2nd and 3rd samples, err_cnt+2, locked falls on the 3rd. It re-locks only after 4 further correct increments.
- Drive 300 mismatches while alternating lock (STAT_W=8) → err_cnt saturates at 0xFF. clr_stat asserted in the same cycle as an err_pulse leaves err_cnt=0.
- Assert rst mid-ramp while locked → locked=0 and counters=0 immediately. en held 0 for 3 cycles leaves all outputs unchanged; the ramp then re-locks per scenario 1.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared definitions for the free-running counter and its sequence checker:
// checker FSM state encoding and the default count width.
package cnt_pkg;

  localparam int CNT_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_e;

endpackage : cnt_pkg

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int STAT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  output logic [STAT_W-1:0] cnt
);

  logic [STAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : sat_counter

// File: rtl/cnt_seq_checker.sv
// Monitors a count stream for +1 (mod 2^WIDTH) steps on each qualified sample,
// tracking lock, sequence errors and wrap-arounds.
module cnt_seq_checker
  import cnt_pkg::*;
#(
  parameter int WIDTH    = CNT_WIDTH,
  parameter int LOCK_N   = 4,
  parameter int UNLOCK_N = 2,
  parameter int STAT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic              clr_stat,
  output logic              locked,
  output logic              err_pulse,
  output logic [STAT_W-1:0] err_cnt,
  output logic              wrap_pulse,
  output logic [STAT_W-1:0] wrap_cnt
);

  localparam int MW = $clog2(LOCK_N + 1);
  localparam int UW = $clog2(UNLOCK_N + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [MW-1:0]    match_q, match_d;
  logic [UW-1:0]    miss_q, miss_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             wrap_pulse_q, wrap_pulse_d;

  logic [WIDTH-1:0] exp_val;
  logic             hit;
  logic             is_wrap;

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    match_d      = match_q;
    miss_d       = miss_q;
    err_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;
    exp_val      = prev_q + WIDTH'(1);
    hit          = (cnt_in == exp_val);
    is_wrap      = (prev_q == '1) && (cnt_in == '0);

    if (en) begin
      prev_d = cnt_in;
      case (state_q)
        IDLE: begin
          // First sample only seeds prev; there is nothing to compare yet.
          state_d = SYNC;
          match_d = '0;
        end
        SYNC: begin
          wrap_pulse_d = is_wrap;
          if (hit) begin
            if (match_q + MW'(1) == MW'(LOCK_N)) begin
              state_d = LOCK;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = match_q + MW'(1);
            end
          end else begin
            match_d = '0;
          end
        end
        LOCK: begin
          wrap_pulse_d = is_wrap;
          if (hit) begin
            miss_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (miss_q + UW'(1) == UW'(UNLOCK_N)) begin
              state_d = SYNC;
              match_d = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + UW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          match_d = '0;
          miss_d  = '0;
        end
      endcase
    end

    locked_d = (state_d == LOCK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      match_q      <= '0;
      miss_q       <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      match_q      <= match_d;
      miss_q       <= miss_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  // Counters see the same-cycle pulse request so they update alongside the pulse flop.
  sat_counter #(.STAT_W(STAT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_pulse_d),
    .clr (clr_stat),
    .cnt (err_cnt)
  );

  sat_counter #(.STAT_W(STAT_W)) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .inc (wrap_pulse_d),
    .clr (clr_stat),
    .cnt (wrap_cnt)
  );

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign wrap_pulse = wrap_pulse_q;

endmodule : cnt_seq_checker

// File: tb/tb_cnt_seq_checker.sv
// Directed plus randomized bench for cnt_seq_checker against a behavioural
// model built from run-length rules (good/bad streaks) rather than FSM states.
module tb_cnt_seq_checker;

  localparam int WIDTH    = 5;
  localparam int LOCK_N   = 4;
  localparam int UNLOCK_N = 2;
  localparam int STAT_W   = 8;
  localparam int STAT_MAX = (1 << STAT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [WIDTH-1:0]  cnt_in = '0;
  logic              clr_stat = 1'b0;
  logic              locked;
  logic              err_pulse;
  logic [STAT_W-1:0] err_cnt;
  logic              wrap_pulse;
  logic [STAT_W-1:0] wrap_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit              m_started;
  bit              m_locked;
  int              m_good_run;
  int              m_bad_run;
  logic [WIDTH-1:0] m_prev;
  bit              m_errp;
  bit              m_wrapp;
  int              m_err;
  int              m_wrap;

  logic [WIDTH-1:0] drv = '0;

  cnt_seq_checker #(
    .WIDTH(WIDTH), .LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N), .STAT_W(STAT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cnt_in     (cnt_in),
    .clr_stat   (clr_stat),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_cnt    (err_cnt),
    .wrap_pulse (wrap_pulse),
    .wrap_cnt   (wrap_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started  = 0;
    m_locked   = 0;
    m_good_run = 0;
    m_bad_run  = 0;
    m_prev     = '0;
    m_errp     = 0;
    m_wrapp    = 0;
    m_err      = 0;
    m_wrap     = 0;
  endtask

  task automatic model_step(input bit e, input logic [WIDTH-1:0] v, input bit c);
    logic [WIDTH-1:0] nxt;
    bit ok;
    m_errp  = 0;
    m_wrapp = 0;
    if (e) begin
      if (m_started) begin
        nxt = m_prev + WIDTH'(1);
        ok  = (v == nxt);
        m_wrapp = (m_prev == {WIDTH{1'b1}}) && (v == '0);
        if (!m_locked) begin
          m_good_run = ok ? m_good_run + 1 : 0;
          if (m_good_run == LOCK_N) begin
            m_locked  = 1;
            m_bad_run = 0;
          end
        end else if (ok) begin
          m_bad_run = 0;
        end else begin
          m_errp = 1;
          m_bad_run++;
          if (m_bad_run == UNLOCK_N) begin
            m_locked   = 0;
            m_good_run = 0;
          end
        end
      end else begin
        m_started  = 1;
        m_good_run = 0;
      end
      m_prev = v;
    end
    if (c) m_err = 0;
    else if (m_errp && m_err < STAT_MAX) m_err++;
    if (c) m_wrap = 0;
    else if (m_wrapp && m_wrap < STAT_MAX) m_wrap++;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".locked"}, 32'(locked), 32'(m_locked));
    chk({tag, ".err_pulse"}, 32'(err_pulse), 32'(m_errp));
    chk({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'(m_wrapp));
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_err));
    chk({tag, ".wrap_cnt"}, 32'(wrap_cnt), 32'(m_wrap));
  endtask

  // One transaction: drive, clock, update model, compare, log.
  task automatic step(input bit e, input logic [WIDTH-1:0] v, input bit c);
    en       = e;
    cnt_in   = v;
    clr_stat = c;
    @(posedge clk);
    #1;
    model_step(e, v, c);
    check_all("step");
    if (e) drv = v;
    $display("t=%0t en=%0b cnt=%02h clr=%0b -> locked=%0b errp=%0b wrapp=%0b err=%0d wrap=%0d",
             $time, e, v, c, locked, err_pulse, wrap_pulse, err_cnt, wrap_cnt);
  endtask

  task automatic ramp(input int n);
    for (int i = 0; i < n; i++) step(1'b1, drv + WIDTH'(1), 1'b0);
  endtask

  initial begin
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);

    // Clean ramp: lock on the sample carrying 4.
    step(1'b1, 5'h00, 1'b0);
    ramp(3);
    chk("prelock", 32'(locked), 32'd0);
    ramp(1);
    chk("lock_on_4", 32'(locked), 32'd1);
    ramp(2);

    // Run up to 0x1F then wrap through 0x00, 0x01.
    ramp(25);
    ramp(2);
    chk("wrap_cnt1", 32'(wrap_cnt), 32'd1);

    // Single glitch 0x07,0x09,0x0A.
    ramp(5);
    step(1'b1, 5'h07, 1'b0);
    step(1'b1, 5'h09, 1'b0);
    chk("glitch_err", 32'(err_pulse), 32'd1);
    step(1'b1, 5'h0A, 1'b0);
    chk("glitch_locked", 32'(locked), 32'd1);

    // Hold 0x05 twice after 0x04: lose lock, then re-acquire.
    ramp(26);
    step(1'b1, 5'h05, 1'b0);
    step(1'b1, 5'h05, 1'b0);
    step(1'b1, 5'h05, 1'b0);
    chk("unlock", 32'(locked), 32'd0);
    ramp(5);

    // Saturate err_cnt by repeatedly locking and holding.
    for (int r = 0; r < 150; r++) begin
      ramp(5);
      step(1'b1, drv, 1'b0);
      step(1'b1, drv, 1'b0);
    end
    chk("err_sat", 32'(err_cnt), 32'(STAT_MAX));

    // Clear coinciding with an error pulse.
    ramp(5);
    step(1'b1, drv, 1'b1);
    chk("clr_vs_inc", 32'(err_cnt), 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit e, c;
      logic [WIDTH-1:0] v;
      e = ($urandom_range(0, 3) != 0);
      v = ($urandom_range(0, 99) < 85) ? drv + WIDTH'(1) : WIDTH'($urandom);
      c = ($urandom_range(0, 29) == 0);
      step(e, v, c);
    end

    // Asynchronous reset mid-ramp while locked.
    ramp(6);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    drv = '0;
    step(1'b0, 5'h11, 1'b0);
    step(1'b0, 5'h12, 1'b0);
    step(1'b0, 5'h13, 1'b0);
    step(1'b1, 5'h00, 1'b0);
    ramp(4);
    chk("relock", 32'(locked), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cnt_seq_checker
